// File: rtl/note_tone_gen_if.sv
// Codec output-FIFO handshake bundle: the tone generator is the master, the codec the slave.
interface note_tone_gen_if;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator with linear attack/release envelope, driven by a one-hot note
// word and feeding the codec output FIFO one sample per accepted write.
module note_tone_gen #(
  parameter logic [23:0] AMP_MAX      = 24'h100000,
  parameter logic [23:0] ATTACK_STEP  = 24'h001000,
  parameter logic [23:0] RELEASE_STEP = 24'h000800
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [8:0]             note,
  note_tone_gen_if.master        codec,
  output logic                   playing
);

  typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} state_e;

  state_e      state_q;
  logic [8:0]  sync1_q, sync2_q, stable_q, note_q;
  logic [23:0] amp_q;
  logic        phase_q;
  logic [6:0]  half_cnt_q, half_period_q, pending_period_q;
  logic        wr_q;
  logic [31:0] sample_q;

  logic        note_valid, fire, half_end;
  logic [6:0]  note_period;
  logic [24:0] amp_up;
  logic [23:0] amp_atk, amp_rel;
  logic [31:0] amp_ext;

  // Half-period in samples, C4 (q) .. D5 (o).
  function automatic logic [6:0] pitch(input logic [8:0] n);
    case (n)
      9'h100:  pitch = 7'd92;
      9'h080:  pitch = 7'd82;
      9'h040:  pitch = 7'd73;
      9'h020:  pitch = 7'd69;
      9'h010:  pitch = 7'd61;
      9'h008:  pitch = 7'd55;
      9'h004:  pitch = 7'd49;
      9'h002:  pitch = 7'd46;
      9'h001:  pitch = 7'd41;
      default: pitch = 7'd0;
    endcase
  endfunction

  always_comb begin
    note_valid  = (note_q != '0) && ((note_q & (note_q - 9'd1)) == '0);
    note_period = pitch(note_q);
    fire        = codec.audio_out_allowed && !wr_q;
    half_end    = (half_cnt_q >= half_period_q - 7'd1);
    amp_up      = {1'b0, amp_q} + {1'b0, ATTACK_STEP};
    amp_atk     = (amp_up >= {1'b0, AMP_MAX}) ? AMP_MAX : amp_up[23:0];
    amp_rel     = (amp_q > RELEASE_STEP) ? (amp_q - RELEASE_STEP) : '0;
    amp_ext     = {8'd0, amp_q};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q          <= StIdle;
      sync1_q          <= '0;
      sync2_q          <= '0;
      stable_q         <= '0;
      note_q           <= '0;
      amp_q            <= '0;
      phase_q          <= 1'b0;
      half_cnt_q       <= '0;
      half_period_q    <= '0;
      pending_period_q <= '0;
      wr_q             <= 1'b0;
      sample_q         <= '0;
    end else begin
      sync1_q  <= note;
      sync2_q  <= sync1_q;
      stable_q <= sync2_q;
      if (sync2_q == stable_q) note_q <= sync2_q;

      wr_q <= fire;
      if (fire) sample_q <= phase_q ? -amp_ext : amp_ext;

      // Pitch changes only take effect at a half-period boundary.
      if (fire && state_q != StIdle) begin
        if (half_end) begin
          half_cnt_q    <= '0;
          phase_q       <= ~phase_q;
          half_period_q <= pending_period_q;
        end else begin
          half_cnt_q <= half_cnt_q + 7'd1;
        end
      end
      if (state_q != StIdle && note_valid) pending_period_q <= note_period;

      unique case (state_q)
        StIdle: begin
          amp_q      <= '0;
          phase_q    <= 1'b0;
          half_cnt_q <= '0;
          if (note_valid) begin
            half_period_q    <= note_period;
            pending_period_q <= note_period;
            state_q          <= StAttack;
          end
        end
        StAttack: begin
          if (!note_valid) begin
            state_q <= StRelease;
          end else if (fire) begin
            amp_q <= amp_atk;
            if (amp_atk == AMP_MAX) state_q <= StSustain;
          end
        end
        StSustain: begin
          if (!note_valid) state_q <= StRelease;
        end
        StRelease: begin
          if (fire) begin
            if (note_valid) begin
              // Re-attack from wherever the release had got to.
              amp_q   <= amp_atk;
              state_q <= StAttack;
            end else if (amp_rel == '0) begin
              amp_q      <= '0;
              phase_q    <= 1'b0;
              half_cnt_q <= '0;
              state_q    <= StIdle;
            end else begin
              amp_q <= amp_rel;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign codec.write_audio_out         = wr_q;
  assign codec.left_channel_audio_out  = sample_q;
  assign codec.right_channel_audio_out = sample_q;
  assign playing                       = (state_q != StIdle);

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: pitch table vectors, randomized backpressure against a closed-form
// envelope/phase model, and directed release, pitch-change, glitch, retrigger and reset cases.
module tb_note_tone_gen;

  localparam int AMP_MAX = 'h100000;
  localparam int ATK     = 'h1000;
  localparam int REL     = 'h800;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] note = 9'h100;
  logic       playing;
  bit         allow_en = 1'b1;
  bit         rand_bp = 1'b0;
  bit         rnd_bit = 1'b1;

  int n_checks = 0;
  int n_pass = 0;

  note_tone_gen_if codec_if ();

  assign codec_if.audio_out_allowed = allow_en & (!rand_bp | rnd_bit);

  note_tone_gen dut (
    .clock   (clk),
    .resetn  (resetn),
    .note    (note),
    .codec   (codec_if),
    .playing (playing)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mag(input logic [31:0] s);
    return s[31] ? -s : s;
  endfunction

  function automatic logic [31:0] signed_amp(input int a, input bit neg);
    logic [31:0] v;
    v = 32'(a);
    return neg ? -v : v;
  endfunction

  function automatic int sat(input int a);
    return (a > AMP_MAX) ? AMP_MAX : a;
  endfunction

  // Handshake rule and output hold, watched on every cycle.
  bit          hs_valid = 1'b0;
  logic        hs_exp = 1'b0;
  bit          have_last = 1'b0;
  logic [31:0] last_sample = '0;

  always @(negedge clk) begin
    if (resetn && hs_valid)
      check("write_handshake", 32'(codec_if.write_audio_out), 32'(hs_exp));
    hs_exp   = codec_if.audio_out_allowed & !codec_if.write_audio_out;
    hs_valid = resetn;
    if (!resetn) begin
      have_last = 1'b0;
    end else if (codec_if.write_audio_out) begin
      check("left_eq_right", codec_if.right_channel_audio_out, codec_if.left_channel_audio_out);
      last_sample = codec_if.left_channel_audio_out;
      have_last   = 1'b1;
    end else if (have_last) begin
      check("sample_hold", codec_if.left_channel_audio_out, last_sample);
    end
  end

  task automatic next_write(output logic [31:0] s, output bit ok);
    ok = 1'b0;
    s  = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (codec_if.write_audio_out) begin
        s  = codec_if.left_channel_audio_out;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("write_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_playing(input bit level, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (playing == level) break;
    end
    check("playing_level", 32'(playing), 32'(level));
  endtask

  task automatic drive_note(input logic [8:0] n);
    @(posedge clk);
    #1 note = n;
  endtask

  typedef struct {
    logic [8:0] note;
    int         half;   // 0 marks an input that must give silence
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] s;
  bit          ok;

  initial begin
    vecs[0]  = '{9'h100, 92};
    vecs[1]  = '{9'h080, 82};
    vecs[2]  = '{9'h040, 73};
    vecs[3]  = '{9'h020, 69};
    vecs[4]  = '{9'h010, 61};
    vecs[5]  = '{9'h008, 55};
    vecs[6]  = '{9'h004, 49};
    vecs[7]  = '{9'h002, 46};
    vecs[8]  = '{9'h001, 41};
    vecs[9]  = '{9'h101, 0};
    vecs[10] = '{9'h000, 0};
    vecs[11] = '{9'h0C0, 0};

    // Reset held with a valid note and the codec ready.
    repeat (3) @(negedge clk);
    check("rst_write", 32'(codec_if.write_audio_out), 32'd0);
    check("rst_left", codec_if.left_channel_audio_out, 32'd0);
    check("rst_right", codec_if.right_channel_audio_out, 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("playing_not_early", 32'(playing), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("playing_by_cycle6", 32'(playing), 32'd1);
    next_write(s, ok);
    drive_note(9'h000);
    wait_playing(1'b0, 5000);

    // Pitch table: count non-negative samples before the first negative one.
    foreach (vecs[v]) begin
      @(posedge clk);
      #1 allow_en = 1'b0;
      note = vecs[v].note;
      repeat (10) @(negedge clk);
      check($sformatf("playing_%03h", vecs[v].note), 32'(playing), 32'(vecs[v].half != 0));
      @(posedge clk);
      #1 allow_en = 1'b1;
      if (vecs[v].half != 0) begin
        int cnt;
        cnt = 0;
        for (int w = 0; w < 300; w++) begin
          next_write(s, ok);
          if (!ok) break;
          if (w == 1) check("attack_second_sample", s, 32'h1000);
          if (s[31]) break;
          cnt++;
        end
        check($sformatf("half_period_%03h", vecs[v].note), 32'(cnt), 32'(vecs[v].half));
        drive_note(9'h000);
        wait_playing(1'b0, 5000);
      end else begin
        next_write(s, ok);
        check("silent_sample", s, 32'd0);
      end
    end

    // Random note, random backpressure: samples must follow the closed-form envelope.
    begin
      int idx, p;
      idx = $urandom_range(0, 8);
      p   = vecs[idx].half;
      @(posedge clk);
      #1 allow_en = 1'b0;
      note = vecs[idx].note;
      wait_playing(1'b1, 20);
      @(posedge clk);
      #1 allow_en = 1'b1;
      rand_bp = 1'b1;
      for (int k = 0; k < 420; k++) begin
        next_write(s, ok);
        if (!ok) break;
        check($sformatf("rand_sample_%0d", k), s, signed_amp(sat(k * ATK), ((k / p) % 2) == 1));
        if (k == 300) begin
          @(posedge clk);
          #1 allow_en = 1'b0;
          for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("frozen_no_write", 32'(codec_if.write_audio_out), 32'd0);
          end
          @(posedge clk);
          #1 allow_en = 1'b1;
        end
        if (k == 350) begin
          drive_note(9'h000);
          drive_note(vecs[idx].note);
        end
      end
      rand_bp = 1'b0;
    end

    // Release from sustain: 512 writes of -0x800 each, ending in IDLE.
    begin
      int prev, cnt;
      prev = AMP_MAX;
      cnt  = 0;
      drive_note(9'h000);
      for (int w = 0; w < 800; w++) begin
        next_write(s, ok);
        if (!ok) break;
        if (mag(s) != 32'(AMP_MAX)) begin
          check("release_step", mag(s), 32'(prev - REL));
          prev = int'(mag(s));
          cnt++;
          if (prev <= REL) break;
        end
      end
      check("release_writes", 32'(cnt + 1), 32'd512);
      check("idle_after_release", 32'(playing), 32'd0);
      next_write(s, ok);
      check("idle_sample_zero", s, 32'd0);
    end

    // Pitch change q->o mid half-period: old half completes, then 41-sample halves.
    begin
      int k_sw, k_end;
      bit ph0;
      k_sw  = 306;
      k_end = (k_sw / 92 + 1) * 92 - 1;
      ph0   = ((k_end / 92) % 2) == 0;
      @(posedge clk);
      #1 allow_en = 1'b0;
      note = 9'h100;
      wait_playing(1'b1, 20);
      @(posedge clk);
      #1 allow_en = 1'b1;
      for (int k = 0; k <= k_end + 200; k++) begin
        next_write(s, ok);
        if (!ok) break;
        if (k <= k_end)
          check($sformatf("pitch_old_%0d", k), s, signed_amp(sat(k * ATK), ((k / 92) % 2) == 1));
        else
          check($sformatf("pitch_new_%0d", k), s,
                signed_amp(AMP_MAX, ph0 ^ ((((k - k_end - 1) / 41) % 2) == 1)));
        if (k == k_sw) drive_note(9'h001);
      end
    end

    // Two-hot note releases; a valid note at amp 0x080000 re-attacks from there.
    begin
      bit found;
      found = 1'b0;
      drive_note(9'h101);
      for (int w = 0; w < 600; w++) begin
        next_write(s, ok);
        if (!ok) break;
        if (mag(s) == 32'h080800) begin
          found = 1'b1;
          break;
        end
      end
      check("release_reaches_080000", 32'(found), 32'd1);
      @(posedge clk);
      #1 allow_en = 1'b0;
      note = 9'h100;
      repeat (12) @(negedge clk);
      check("retrigger_wait_playing", 32'(playing), 32'd1);
      @(posedge clk);
      #1 allow_en = 1'b1;
      for (int j = 0; j <= 140; j++) begin
        next_write(s, ok);
        if (!ok) break;
        check($sformatf("retrigger_%0d", j), mag(s), 32'(sat('h080000 + j * ATK)));
      end
    end

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_write", 32'(codec_if.write_audio_out), 32'd0);
    check("async_rst_left", codec_if.left_channel_audio_out, 32'd0);
    check("async_rst_right", codec_if.right_channel_audio_out, 32'd0);
    check("async_rst_playing", 32'(playing), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
